// File: rtl/obi_rr_arbiter.sv
// N-to-1 OBI arbiter: round-robin manager selection with address-phase
// locking, and in-order response routing through an index FIFO.
module obi_rr_arbiter #(
    parameter int NUM_MASTERS     = 2,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic [NUM_MASTERS-1:0]                   m_req_i,
    output logic [NUM_MASTERS-1:0]                   m_gnt_o,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]        m_addr_i,
    input  logic [NUM_MASTERS-1:0]                   m_we_i,
    input  logic [NUM_MASTERS*(DATA_WIDTH/8)-1:0]    m_be_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]        m_wdata_i,
    output logic [NUM_MASTERS-1:0]                   m_rvalid_o,
    output logic [DATA_WIDTH-1:0]                    m_rdata_o,
    output logic                                     s_req_o,
    input  logic                                     s_gnt_i,
    output logic [ADDR_WIDTH-1:0]                    s_addr_o,
    output logic                                     s_we_o,
    output logic [DATA_WIDTH/8-1:0]                  s_be_o,
    output logic [DATA_WIDTH-1:0]                    s_wdata_o,
    input  logic                                     s_rvalid_i,
    input  logic [DATA_WIDTH-1:0]                    s_rdata_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding_o,
    output logic                                     err_rvalid_o
);
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int OCC_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [IDX_W-1:0] r_ptr;
    logic             r_lock_vld;
    logic [IDX_W-1:0] r_lock_idx;
    logic [IDX_W-1:0] r_fifo [MAX_OUTSTANDING];
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W-1:0] r_rd;
    logic [OCC_W-1:0] r_cnt;
    logic             r_err;

    logic             w_lock_eff;
    logic [IDX_W-1:0] w_win;
    logic             w_found;
    logic             w_full;
    logic             w_empty;
    logic             w_hs;
    logic             w_pop;
    logic [IDX_W-1:0] w_head;

    // A lock only holds while the locked manager keeps requesting; a dropped
    // request releases it in the same cycle.
    assign w_lock_eff = r_lock_vld & m_req_i[r_lock_idx];
    assign w_full     = (r_cnt == OCC_W'(MAX_OUTSTANDING));
    assign w_empty    = (r_cnt == '0);
    assign s_req_o    = (|m_req_i) & ~w_full;
    assign w_hs       = s_req_o & s_gnt_i;
    assign w_pop      = s_rvalid_i & ~w_empty;
    assign w_head     = r_fifo[r_rd];

    // Winner: locked index, else first requester searching upward from r_ptr
    always_comb begin
        int j;
        j       = 0;
        w_found = 1'b0;
        w_win   = r_lock_idx;
        if (!w_lock_eff) begin
            w_win = '0;
            for (int i = 0; i < NUM_MASTERS; i++) begin
                j = int'(r_ptr) + i;
                if (j >= NUM_MASTERS) j = j - NUM_MASTERS;
                if (!w_found && m_req_i[j]) begin
                    w_found = 1'b1;
                    w_win   = IDX_W'(j);
                end
            end
        end
    end

    // Forward the winner's address-phase signals
    always_comb begin
        s_addr_o  = m_addr_i[int'(w_win)*ADDR_WIDTH +: ADDR_WIDTH];
        s_we_o    = m_we_i[w_win];
        s_be_o    = m_be_i[int'(w_win)*BE_W +: BE_W];
        s_wdata_o = m_wdata_i[int'(w_win)*DATA_WIDTH +: DATA_WIDTH];
    end

    // Grant goes only to the winner, and only on an actual handshake
    always_comb begin
        m_gnt_o = '0;
        if (w_hs) m_gnt_o[w_win] = 1'b1;
    end

    // Response routed to the manager at the FIFO head; data is broadcast
    always_comb begin
        m_rvalid_o = '0;
        if (w_pop) m_rvalid_o[w_head] = 1'b1;
    end
    assign m_rdata_o = s_rdata_i;

    // RR pointer and address-phase lock
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_ptr      <= '0;
            r_lock_vld <= 1'b0;
            r_lock_idx <= '0;
        end else begin
            if (w_hs) begin
                r_ptr      <= (int'(w_win) == NUM_MASTERS-1) ? '0 : w_win + IDX_W'(1);
                r_lock_vld <= 1'b0;
            end else if (s_req_o) begin
                // stalled request: pin selection until granted
                r_lock_vld <= 1'b1;
                r_lock_idx <= w_win;
            end else begin
                // full keeps the lock; a dropped request releases it
                r_lock_vld <= w_lock_eff;
            end
        end
    end

    // Outstanding-transaction FIFO of winner indices
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) r_fifo[i] <= '0;
        end else begin
            if (w_hs) begin
                r_fifo[r_wr] <= w_win;
                r_wr <= (r_wr == PTR_W'(MAX_OUTSTANDING-1)) ? '0 : r_wr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd <= (r_rd == PTR_W'(MAX_OUTSTANDING-1)) ? '0 : r_rd + PTR_W'(1);
            end
            case ({w_hs, w_pop})
                2'b10:   r_cnt <= r_cnt + OCC_W'(1);
                2'b01:   r_cnt <= r_cnt - OCC_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Sticky flag for a response arriving with nothing outstanding
    always_ff @(posedge clk_i) begin
        if (!rst_ni) r_err <= 1'b0;
        else if (s_rvalid_i && w_empty) r_err <= 1'b1;
    end

    assign outstanding_o = r_cnt;
    assign err_rvalid_o  = r_err;

endmodule

// File: doc/obi_rr_arbiter.md
Name: obi_rr_arbiter

Overview:
- N-to-1 OBI arbiter. Multiple core-side OBI managers (instr fetch, data LSU, future DMA/coprocessor ports) share one memory-side OBI subordinate port.
- Sits between the core wrapper's instr_*/data_* buses and a single-ported memory.
- Round-robin arbitration. Address-phase locking until grant. In-order response routing through an outstanding-transaction FIFO.

Parameters:
- NUM_MASTERS, 2, number of manager ports (>=2).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; byte-enable width BE_W = DATA_WIDTH/8.
- MAX_OUTSTANDING, 2, depth of the response-routing FIFO (>=1); IDX_W = max(1, clog2(NUM_MASTERS)).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- m_req_i  in  NUM_MASTERS  per-manager request.
- m_gnt_o  out  NUM_MASTERS  per-manager grant.
- m_addr_i  in  NUM_MASTERS*ADDR_WIDTH  addresses; manager k at slice [k*ADDR_WIDTH +: ADDR_WIDTH].
- m_we_i  in  NUM_MASTERS  write enables.
- m_be_i  in  NUM_MASTERS*BE_W  byte enables.
- m_wdata_i  in  NUM_MASTERS*DATA_WIDTH  write data.
- m_rvalid_o  out  NUM_MASTERS  per-manager response valid.
- m_rdata_o  out  DATA_WIDTH  response data, broadcast to all managers.
- s_req_o  out  1  subordinate request.
- s_gnt_i  in  1  subordinate grant.
- s_addr_o  out  ADDR_WIDTH  forwarded address.
- s_we_o  out  1  forwarded write enable.
- s_be_o  out  BE_W  forwarded byte enables.
- s_wdata_o  out  DATA_WIDTH  forwarded write data.
- s_rvalid_i  in  1  subordinate response valid.
- s_rdata_i  in  DATA_WIDTH  subordinate response data.
- outstanding_o  out  clog2(MAX_OUTSTANDING+1)  current FIFO occupancy.
- err_rvalid_o  out  1  sticky flag: s_rvalid_i received with no transaction outstanding.

Behaviour:
- Reset (rst_ni=0 sampled at clk_i edge): RR pointer=0, lock cleared, FIFO empty, outstanding_o=0, err_rvalid_o=0. All m_gnt_o, m_rvalid_o and s_req_o are 0 while the FIFO is empty and no m_req_i is high. Reset mid-transaction discards all outstanding entries; later s_rvalid_i sets err_rvalid_o.
- Selection is combinational, so the request path has zero added latency.
  - Unlocked: the winner is the first requesting manager, searching upward with wrap from index ptr.
  - Locked: the winner is the locked index.
- s_req_o = (any m_req_i) AND NOT full. s_addr_o, s_we_o, s_be_o and s_wdata_o come from the winner's slices.
- m_gnt_o[winner] = s_gnt_i AND s_req_o. All other grants are 0.
- Lock register:
  - Set to the winner when s_req_o=1 and s_gnt_i=0. This enforces OBI address-phase stability: a stalled request is never switched to another manager.
  - Cleared on handshake (s_req_o & s_gnt_i).
  - If the locked manager drops m_req_i (protocol violation), the lock clears and selection is unlocked in the same cycle.
- On handshake: ptr <= (winner+1) mod NUM_MASTERS, and the winner index is pushed into the FIFO.
- Full = occupancy == MAX_OUTSTANDING.
  - When full, s_req_o=0 and all grants are 0, even if a pop happens in the same cycle. Acceptance resumes the following cycle.
  - The lock is retained while full.
- Response path:
  - s_rvalid_i with the FIFO non-empty: m_rvalid_o[head]=1 combinationally, m_rdata_o=s_rdata_i, FIFO pops.
  - Responses are in order; no IDs are used.
- Simultaneous push and pop when not full: occupancy is unchanged and both operations take effect.
- s_rvalid_i with the FIFO empty: no m_rvalid_o is asserted, and err_rvalid_o<=1 until reset.
- FIFO pointers wrap modulo MAX_OUTSTANDING. The design must work for non-power-of-two depths.
- outstanding_o is registered and reflects pushes and pops after the clock edge.

Test Plan:
- Single manager, NUM_MASTERS=2, MAX_OUTSTANDING=2. m_req_i=01, addr 0x20000, s_gnt_i=1; rvalid next cycle with rdata 0xDEADBEEF -> m_gnt_o=01 in the same cycle, outstanding_o 1 then 0, m_rvalid_o=01, m_rdata_o=0xDEADBEEF.
- Both managers request continuously, s_gnt_i=1 -> grants alternate 01, 10, 01, 10 starting with 01 after reset.
- Manager 0 requests addr 0x100 with s_gnt_i=0 for 3 cycles while manager 1 raises req -> s_addr_o stays 0x100 throughout. gnt goes to 0 first, then to 1 on the next grant.
- Back-pressure: 2 accepted requests with no rvalid -> outstanding_o=2, s_req_o=0 despite m_req_i=11. One rvalid -> the next request is accepted the cycle after.
- Routing: accept M1 then M0, then 2 rvalids with data 0xA, 0xB -> m_rvalid_o=10 with 0xA, then 01 with 0xB.
- Reset asserted with 1 outstanding, then s_rvalid_i=1 -> no m_rvalid_o, err_rvalid_o=1 and sticky.
